uart_tx: RTL and testbench

UART transmitter, the transmit-side counterpart to the receive path of the UART.
- Frame format: 8N1 (one start bit, 8 data bits LSB first, one stop bit).
- Bit timing comes from an internal baud counter. The counter restarts at frame acceptance, so every bit cell is exactly BAUD_DIV clock cycles long.
- Sits between system logic (byte + start strobe) and the serial pin `tx`.

---
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with an internal baud counter.
// Each bit cell lasts exactly BAUD_DIV clock cycles, counted from the edge
// that accepts the byte. tx and ready are registered, so they only change
// on the accepting edge and on bit-end tick edges.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1, 11 bit cells per frame).
module uart_tx #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int            CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
        ,S_PARITY = 3'd3
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        r_ready;
    logic        w_ready_nxt;
    logic        w_tick;
    logic        w_accept;

`ifdef UART_TX_PARITY_EN
    logic        r_par;
    logic        w_par_nxt;

    // Even parity of a byte: 1 when the byte holds an odd number of ones.
    function automatic logic f_even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    assign w_tick   = (r_cnt == CNT_MAX);
    assign w_accept = start & r_ready;
    assign tx       = r_tx;
    assign ready    = r_ready;

    // Next-state, counter, shift register and output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_ready_nxt = r_ready;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = CNT_ZERO;
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = data;
                    w_tx_nxt    = 1'b0;
                    w_ready_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = f_even_parity(data);
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_cnt_nxt = w_tick ? CNT_ZERO : r_cnt + CW'(1);
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                w_cnt_nxt = w_tick ? CNT_ZERO : r_cnt + CW'(1);
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_par;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_cnt_nxt = w_tick ? CNT_ZERO : r_cnt + CW'(1);
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                w_cnt_nxt = w_tick ? CNT_ZERO : r_cnt + CW'(1);
                w_tx_nxt  = 1'b1;
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset overrides any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_shift <= 8'h00;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_ready <= w_ready_nxt;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx with BAUD_DIV=4.
// Expected serial frames are written out by hand (first bit on the left).
module tb_uart_tx;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * BD;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       ready;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;   // start, d0..d7, stop -- leftmost bit first
        logic       par;     // even parity bit of d
    } vec_t;

    vec_t vecs[6];

    uart_tx #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .tx    (tx),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [9:0] fr, input logic p, input int idx);
`ifdef UART_TX_PARITY_EN
        if (idx < 9) return fr[9 - idx];
        else if (idx == 9) return p;
        else return 1'b1;
`else
        if (p === 1'bx) return 1'bx;
        return fr[9 - idx];
`endif
    endfunction

    // Called right after the accepting edge. Checks every cycle of the frame,
    // optionally pulses start with 0xFF at cycle inj_k, and ends right after
    // the final tick edge with ready expected high.
    task automatic check_frame(input logic [9:0] fr, input logic p, input int inj_k);
        for (int k = 1; k <= FL; k++) begin
            chk("tx_bit", tx, exp_bit(fr, p, (k - 1) / BD));
            chk("ready_low", ready, 1'b0);
            if (inj_k > 0 && k == inj_k) begin
                start = 1'b1;
                data  = 8'hFF;
            end
            if (inj_k > 0 && k == inj_k + 1) start = 1'b0;
            cyc();
        end
        chk("ready_end", ready, 1'b1);
        chk("tx_end", tx, 1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic [9:0] fr, input logic p, input int inj_k);
        start = 1'b1;
        data  = d;
        cyc();
        start = 1'b0;
        data  = ~d;
        check_frame(fr, p, inj_k);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("idle_tx", tx, 1'b1);
            chk("idle_ready", ready, 1'b1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        data  = 8'h00;

        vecs[0] = '{8'h55, 10'b0101010101, 1'b0};
        vecs[1] = '{8'h81, 10'b0100000011, 1'b0};
        vecs[2] = '{8'h0F, 10'b0111100001, 1'b0};
        vecs[3] = '{8'hF0, 10'b0000011111, 1'b0};
        vecs[4] = '{8'h07, 10'b0111000001, 1'b1};
        vecs[5] = '{8'h03, 10'b0110000001, 1'b0};

        // Reset: 3 cycles, then idle line for 20 cycles
        repeat (3) cyc();
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle20_tx", tx, 1'b1);
            chk("idle20_ready", ready, 1'b1);
        end

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].d, vecs[v].frame, vecs[v].par, 0);
        end

        // 0xA3 with an ignored start(0xFF) request at cycle 10
        send(8'hA3, 10'b0110001011, 1'b0, 10);

        // Reset mid-frame: accept 0x00, rst on cycle 14
        start = 1'b1;
        data  = 8'h00;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            chk("abort_tx", tx, 1'b0);
            chk("abort_ready", ready, 1'b0);
            cyc();
        end
        rst = 1'b1;
        cyc();
        chk("abort_rst_tx", tx, 1'b1);
        chk("abort_rst_ready", ready, 1'b1);
        rst = 1'b0;
        cyc();
        chk("abort_idle_tx", tx, 1'b1);
        send(8'h81, 10'b0100000011, 1'b0, 0);

        // Back-to-back with start held high
        start = 1'b1;
        data  = 8'h0F;
        cyc();
        data  = 8'hF0;
        check_frame(10'b0111100001, 1'b0, 0);
        cyc();
        chk("b2b_ready_1cyc", ready, 1'b0);
        chk("b2b_start_bit", tx, 1'b0);
        start = 1'b0;
        data  = 8'h00;
        check_frame(10'b0000011111, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("b2b_idle_tx", tx, 1'b1);
            chk("b2b_idle_ready", ready, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
